// File: rtl/mant_normalizer.sv
// Post-add mantissa normalizer: one-bit-per-cycle right/left shift with exponent
// adjust, registered result held under a valid/ready handshake.

module alu_a (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] sum
);
   logic [8:0] c;
   assign c[0] = c_in;
   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
endmodule

module mant_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [16:0] in_mant,
   input  logic [7:0]  in_exp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic [15:0] out_mant,
   output logic [7:0]  out_exp,
   output logic        out_zero,
   output logic        out_ovf,
   output logic        out_unf
);
   typedef enum logic [1:0] {IDLE, RIGHT, LEFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [16:0] mant_q, mant_d;
   logic [7:0]  exp_q, exp_d, exp_adj;
   logic        sign_q, sign_d, zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

   // +1 for a carry shift-right, -1 (add 8'hFF) for each shift-left
   alu_a u_exp_adj (
      .a    (exp_q),
      .b    ((state_q == RIGHT) ? 8'h01 : 8'hFF),
      .c_in (1'b0),
      .sum  (exp_adj)
   );

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            sign_d = in_sign;
            mant_d = in_mant;
            exp_d  = in_exp;
            zero_d = 1'b0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            if (in_mant == 17'h0) begin
               mant_d  = 17'h0;
               exp_d   = 8'h80;
               sign_d  = 1'b0;
               zero_d  = 1'b1;
               state_d = DONE;
            end else if (in_mant[16]) state_d = RIGHT;
            else if (in_mant[15])     state_d = DONE;
            else                      state_d = LEFT;
         end
         RIGHT: begin
            if (exp_q == 8'h7F) begin
               ovf_d  = 1'b1;
               mant_d = 17'h0FFFF;
            end else begin
               mant_d = {1'b0, mant_q[16:1]};
               exp_d  = exp_adj;
            end
            state_d = DONE;
         end
         LEFT: begin
            // exponent already at minimum: flush rather than wrap
            if (exp_q == 8'h80) begin
               unf_d   = 1'b1;
               zero_d  = 1'b1;
               mant_d  = 17'h0;
               sign_d  = 1'b0;
               state_d = DONE;
            end else begin
               mant_d = {mant_q[15:0], 1'b0};
               exp_d  = exp_adj;
               if (mant_q[14]) state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sign  = sign_q;
   assign out_mant  = mant_q[15:0];
   assign out_exp   = exp_q;
   assign out_zero  = zero_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;
endmodule
